// File: rtl/reorder_buffer_mw.sv
// Multi-wakeup, multi-retire reorder buffer: in-order allocate, out-of-order
// completion, in-order retirement of up to RETIRE_W entries per cycle.
module reorder_buffer_mw #(
  parameter int DEPTH      = 64,
  parameter int IDX_W      = 6,
  parameter int TAG_W      = 6,
  parameter int NUM_WAKEUP = 3,
  parameter int RETIRE_W   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enqueue_enable,
  input  logic [TAG_W-1:0]              enqueue_old_tag,
  input  logic                          enqueue_has_old_tag,
  output logic                          enqueue_ready,
  output logic [IDX_W-1:0]              next_rob_index,
  input  logic [NUM_WAKEUP-1:0]         wakeup_active,
  input  logic [NUM_WAKEUP*IDX_W-1:0]   wakeup_rob_index,
  output logic [RETIRE_W-1:0]           freed_valid,
  output logic [RETIRE_W*TAG_W-1:0]     freed_tag,
  output logic [$clog2(RETIRE_W):0]     retire_count,
  output logic                          empty,
  output logic [IDX_W:0]                count
);

  localparam int RC_W = $clog2(RETIRE_W) + 1;

  // Handshake: an enqueue is accepted at the rising edge where
  // enqueue_enable && enqueue_ready; enqueue_ready depends only on registered
  // count, never on this cycle's retirement.

  logic [DEPTH-1:0]    valid_q;
  logic [DEPTH-1:0]    complete_q;
  logic [DEPTH-1:0]    has_old_q;
  logic [TAG_W-1:0]    old_tag_q [DEPTH];
  logic [IDX_W-1:0]    head_q;
  logic [IDX_W-1:0]    tail_q;
  logic [IDX_W:0]      count_q;

  logic [RETIRE_W-1:0]       freed_valid_q;
  logic [RETIRE_W*TAG_W-1:0] freed_tag_q;
  logic [RC_W-1:0]           retire_count_q;

  logic                enq_fire;
  logic [IDX_W-1:0]    win_idx [RETIRE_W];
  logic [RETIRE_W-1:0] retire_mask;
  logic [RC_W-1:0]     retire_n;
  logic                run;

  assign enqueue_ready  = (count_q < (IDX_W+1)'(DEPTH));
  assign enq_fire       = enqueue_enable && enqueue_ready;
  assign next_rob_index = tail_q;
  assign empty          = (count_q == '0);
  assign count          = count_q;
  assign freed_valid    = freed_valid_q;
  assign freed_tag      = freed_tag_q;
  assign retire_count   = retire_count_q;

  // Retire window wraps naturally through the IDX_W-bit add.
  always_comb begin
    for (int r = 0; r < RETIRE_W; r++) begin
      win_idx[r] = head_q + IDX_W'(r);
    end
  end

  // Leading run of valid&complete entries; the first miss blocks all younger.
  always_comb begin
    retire_mask = '0;
    retire_n    = '0;
    run         = 1'b1;
    for (int r = 0; r < RETIRE_W; r++) begin
      if (run && ((IDX_W+1)'(r) < count_q) &&
          valid_q[win_idx[r]] && complete_q[win_idx[r]]) begin
        retire_mask[r] = 1'b1;
        retire_n       = retire_n + 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q        <= '0;
      complete_q     <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      freed_valid_q  <= '0;
      freed_tag_q    <= '0;
      retire_count_q <= '0;
    end else begin
      // Wakeups only land on already-valid entries, so the slot being
      // allocated this cycle cannot be marked complete early.
      for (int k = 0; k < NUM_WAKEUP; k++) begin
        if (wakeup_active[k] && valid_q[wakeup_rob_index[k*IDX_W +: IDX_W]]) begin
          complete_q[wakeup_rob_index[k*IDX_W +: IDX_W]] <= 1'b1;
        end
      end
      // Retire clears after wakeup so a late redundant wakeup cannot resurrect it.
      for (int r = 0; r < RETIRE_W; r++) begin
        if (retire_mask[r]) begin
          valid_q[win_idx[r]]    <= 1'b0;
          complete_q[win_idx[r]] <= 1'b0;
        end
      end
      if (enq_fire) begin
        valid_q[tail_q]    <= 1'b1;
        complete_q[tail_q] <= 1'b0;
        tail_q             <= tail_q + 1'b1;
      end
      head_q  <= head_q + IDX_W'(retire_n);
      count_q <= count_q + (IDX_W+1)'(enq_fire) - (IDX_W+1)'(retire_n);

      for (int r = 0; r < RETIRE_W; r++) begin
        freed_valid_q[r] <= retire_mask[r] && has_old_q[win_idx[r]];
        freed_tag_q[r*TAG_W +: TAG_W] <= (retire_mask[r] && has_old_q[win_idx[r]]) ?
                                         old_tag_q[win_idx[r]] : '0;
      end
      retire_count_q <= retire_n;
    end
  end

  // Payload needs no reset; it is only ever read behind a valid bit.
  always_ff @(posedge clk) begin
    if (!reset && enq_fire) begin
      has_old_q[tail_q] <= enqueue_has_old_tag;
      old_tag_q[tail_q] <= enqueue_old_tag;
    end
  end

endmodule

// File: tb/tb_reorder_buffer_mw.sv
// Directed bench for reorder_buffer_mw at default parameters (DEPTH 64,
// three wakeup ports, two retire slots).
module tb_reorder_buffer_mw;

  logic        clk = 1'b0;
  logic        reset;
  logic        enqueue_enable;
  logic [5:0]  enqueue_old_tag;
  logic        enqueue_has_old_tag;
  logic        enqueue_ready;
  logic [5:0]  next_rob_index;
  logic [2:0]  wakeup_active;
  logic [17:0] wakeup_rob_index;
  logic [1:0]  freed_valid;
  logic [11:0] freed_tag;
  logic [1:0]  retire_count;
  logic        empty;
  logic [6:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  reorder_buffer_mw dut (
    .clk                 (clk),
    .reset               (reset),
    .enqueue_enable      (enqueue_enable),
    .enqueue_old_tag     (enqueue_old_tag),
    .enqueue_has_old_tag (enqueue_has_old_tag),
    .enqueue_ready       (enqueue_ready),
    .next_rob_index      (next_rob_index),
    .wakeup_active       (wakeup_active),
    .wakeup_rob_index    (wakeup_rob_index),
    .freed_valid         (freed_valid),
    .freed_tag           (freed_tag),
    .retire_count        (retire_count),
    .empty               (empty),
    .count               (count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enqueue_enable = 1'b0;
    enqueue_old_tag = '0;
    enqueue_has_old_tag = 1'b0;
    wakeup_active = '0;
    wakeup_rob_index = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic enq(input logic [5:0] tag, input logic has_old);
    enqueue_enable = 1'b1;
    enqueue_old_tag = tag;
    enqueue_has_old_tag = has_old;
    step();
    enqueue_enable = 1'b0;
  endtask

  task automatic wake(input logic [2:0] act, input logic [5:0] i0, input logic [5:0] i1,
                      input logic [5:0] i2);
    wakeup_active = act;
    wakeup_rob_index = {i2, i1, i0};
    step();
    wakeup_active = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (count !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++; if (enqueue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", enqueue_ready); end
    n_checks++; if (next_rob_index !== 6'd0) begin n_fail++; $display("FAIL reset_next_idx: got %0d want 0", next_rob_index); end
    n_checks++; if (freed_valid !== 2'b00 || retire_count !== 2'd0 || freed_tag !== 12'd0) begin
      n_fail++; $display("FAIL reset_freed: got fv=%b rc=%0d tag=%h want 0/0/0", freed_valid, retire_count, freed_tag); end
  endtask

  task automatic test_basic_retire();
    do_reset();
    enq(6'd5, 1'b1); enq(6'd6, 1'b1); enq(6'd7, 1'b1);
    n_checks++; if (count !== 7'd3 || next_rob_index !== 6'd3) begin
      n_fail++; $display("FAIL basic_alloc: got count=%0d next=%0d want 3/3", count, next_rob_index); end
    wake(3'b111, 6'd0, 6'd1, 6'd2);
    n_checks++; if (retire_count !== 2'd0 || freed_valid !== 2'b00) begin
      n_fail++; $display("FAIL basic_no_early_retire: got rc=%0d fv=%b want 0/00", retire_count, freed_valid); end
    step();
    n_checks++; if (retire_count !== 2'd2 || freed_valid !== 2'b11 || freed_tag !== {6'd6, 6'd5}) begin
      n_fail++; $display("FAIL basic_retire2: got rc=%0d fv=%b tag=%h want 2/11/185", retire_count, freed_valid, freed_tag); end
    step();
    n_checks++; if (retire_count !== 2'd1 || freed_valid !== 2'b01 || freed_tag[5:0] !== 6'd7 || empty !== 1'b1) begin
      n_fail++; $display("FAIL basic_retire1: got rc=%0d fv=%b tag0=%0d empty=%b want 1/01/7/1",
                         retire_count, freed_valid, freed_tag[5:0], empty); end
    step();
    n_checks++; if (retire_count !== 2'd0 || freed_valid !== 2'b00) begin
      n_fail++; $display("FAIL basic_idle: got rc=%0d fv=%b want 0/00", retire_count, freed_valid); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    enq(6'd10, 1'b1); enq(6'd11, 1'b1); enq(6'd12, 1'b1);
    wake(3'b001, 6'd2, 6'd0, 6'd0);
    wake(3'b001, 6'd1, 6'd0, 6'd0);
    step();
    n_checks++; if (retire_count !== 2'd0 || count !== 7'd3) begin
      n_fail++; $display("FAIL ooo_blocked: got rc=%0d count=%0d want 0/3", retire_count, count); end
    wake(3'b010, 6'd0, 6'd0, 6'd0);
    n_checks++; if (retire_count !== 2'd0) begin
      n_fail++; $display("FAIL ooo_same_cycle: got rc=%0d want 0", retire_count); end
    step();
    n_checks++; if (retire_count !== 2'd2 || freed_valid !== 2'b11 || freed_tag !== {6'd11, 6'd10} || count !== 7'd1) begin
      n_fail++; $display("FAIL ooo_retire2: got rc=%0d fv=%b tag=%h count=%0d want 2/11/2ca/1",
                         retire_count, freed_valid, freed_tag, count); end
    step();
    n_checks++; if (retire_count !== 2'd1 || freed_valid !== 2'b01 || freed_tag[5:0] !== 6'd12 || count !== 7'd0) begin
      n_fail++; $display("FAIL ooo_retire1: got rc=%0d fv=%b tag0=%0d count=%0d want 1/01/12/0",
                         retire_count, freed_valid, freed_tag[5:0], count); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 64; i++) enq(6'(i + 1), 1'b1);
    n_checks++; if (count !== 7'd64 || enqueue_ready !== 1'b0 || next_rob_index !== 6'd0) begin
      n_fail++; $display("FAIL full_state: got count=%0d ready=%b next=%0d want 64/0/0", count, enqueue_ready, next_rob_index); end
    enqueue_enable = 1'b1; enqueue_old_tag = 6'd50; enqueue_has_old_tag = 1'b1;
    wake(3'b001, 6'd0, 6'd0, 6'd0);
    n_checks++; if (count !== 7'd64 || next_rob_index !== 6'd0 || enqueue_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_reject: got count=%0d next=%0d ready=%b want 64/0/0", count, next_rob_index, enqueue_ready); end
    step();
    n_checks++; if (count !== 7'd63 || next_rob_index !== 6'd0 || enqueue_ready !== 1'b1 ||
                    retire_count !== 2'd1 || freed_tag[5:0] !== 6'd1) begin
      n_fail++; $display("FAIL full_retire_reject: got count=%0d next=%0d ready=%b rc=%0d tag0=%0d want 63/0/1/1/1",
                         count, next_rob_index, enqueue_ready, retire_count, freed_tag[5:0]); end
    step();
    enqueue_enable = 1'b0;
    n_checks++; if (count !== 7'd64 || next_rob_index !== 6'd1 || enqueue_ready !== 1'b0 || retire_count !== 2'd0) begin
      n_fail++; $display("FAIL full_refill: got count=%0d next=%0d ready=%b rc=%0d want 64/1/0/0",
                         count, next_rob_index, enqueue_ready, retire_count); end
  endtask

  task automatic test_wrap();
    int budget;
    do_reset();
    for (int i = 0; i < 63; i++) enq(6'd0, 1'b0);
    for (int c = 0; c < 21; c++) wake(3'b111, 6'(3*c), 6'(3*c + 1), 6'(3*c + 2));
    budget = 100;
    while (empty !== 1'b1 && budget > 0) begin step(); budget--; end
    n_checks++; if (budget == 0) begin n_fail++; $display("FAIL wrap_drain_timeout: got count=%0d want 0", count); end
    n_checks++; if (next_rob_index !== 6'd63) begin n_fail++; $display("FAIL wrap_tail: got %0d want 63", next_rob_index); end
    enq(6'd63, 1'b1); enq(6'd0, 1'b1);
    n_checks++; if (count !== 7'd2 || next_rob_index !== 6'd1) begin
      n_fail++; $display("FAIL wrap_alloc: got count=%0d next=%0d want 2/1", count, next_rob_index); end
    wake(3'b011, 6'd63, 6'd0, 6'd0);
    step();
    n_checks++; if (retire_count !== 2'd2 || freed_valid !== 2'b11 || freed_tag !== {6'd0, 6'd63} ||
                    empty !== 1'b1 || next_rob_index !== 6'd1) begin
      n_fail++; $display("FAIL wrap_retire: got rc=%0d fv=%b tag=%h empty=%b next=%0d want 2/11/03f/1/1",
                         retire_count, freed_valid, freed_tag, empty, next_rob_index); end
  endtask

  task automatic test_no_old_tag();
    do_reset();
    enq(6'd9, 1'b0); enq(6'd4, 1'b1);
    wake(3'b011, 6'd0, 6'd1, 6'd0);
    step();
    n_checks++; if (retire_count !== 2'd2 || freed_valid !== 2'b10 || freed_tag[11:6] !== 6'd4) begin
      n_fail++; $display("FAIL no_old_tag: got rc=%0d fv=%b tag1=%0d want 2/10/4", retire_count, freed_valid, freed_tag[11:6]); end
  endtask

  task automatic test_wake_on_enqueue();
    do_reset();
    enqueue_enable = 1'b1; enqueue_old_tag = 6'd33; enqueue_has_old_tag = 1'b1;
    wake(3'b001, 6'd0, 6'd0, 6'd0);
    enqueue_enable = 1'b0;
    step(); step();
    n_checks++; if (retire_count !== 2'd0 || count !== 7'd1) begin
      n_fail++; $display("FAIL wake_on_enq_ignored: got rc=%0d count=%0d want 0/1", retire_count, count); end
    wake(3'b100, 6'd0, 6'd0, 6'd0);
    step();
    n_checks++; if (retire_count !== 2'd1 || freed_valid !== 2'b01 || freed_tag[5:0] !== 6'd33) begin
      n_fail++; $display("FAIL wake_on_enq_retire: got rc=%0d fv=%b tag0=%0d want 1/01/33", retire_count, freed_valid, freed_tag[5:0]); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 10; i++) enq(6'(20 + i), 1'b1);
    wake(3'b111, 6'd2, 6'd3, 6'd4);
    wake(3'b001, 6'd5, 6'd0, 6'd0);
    n_checks++; if (count !== 7'd10 || retire_count !== 2'd0) begin
      n_fail++; $display("FAIL mid_reset_pre: got count=%0d rc=%0d want 10/0", count, retire_count); end
    reset = 1'b1; enqueue_enable = 1'b1; enqueue_old_tag = 6'd40;
    wake(3'b001, 6'd0, 6'd0, 6'd0);
    reset = 1'b0; enqueue_enable = 1'b0;
    n_checks++; if (count !== 7'd0 || freed_valid !== 2'b00 || next_rob_index !== 6'd0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_state: got count=%0d fv=%b next=%0d empty=%b want 0/00/0/1",
                         count, freed_valid, next_rob_index, empty); end
    for (int c = 0; c < 4; c++) begin
      wake(3'b111, 6'd0, 6'd1, 6'(2 + c));
      n_checks++; if (freed_valid !== 2'b00 || retire_count !== 2'd0 || count !== 7'd0) begin
        n_fail++; $display("FAIL mid_reset_no_free: got fv=%b rc=%0d count=%0d want 00/0/0", freed_valid, retire_count, count); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_retire();
    test_out_of_order();
    test_full();
    test_wrap();
    test_no_old_tag();
    test_wake_on_enqueue();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
